// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer owner: display scan-out always takes the RAM, a
// request/ack CPU port uses the free cycles, and fetched words become pixels.
//
// state  | meaning
// S_IDLE | no CPU op held; a request is captured into the holding registers
// S_PEND | CPU op held; issued in the first cycle without a display fetch
// S_RESP | cpu_ack pulse; read data forwarded and kept in r_rdata
module vga_fb_arbiter #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int BPP   = 4,
    parameter int PPW   = 4,
    parameter int AW    = 17
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_pix_tick,
    input  logic                 i_video_on,
    input  logic [9:0]           i_x,
    input  logic [9:0]           i_y,
    output logic                 o_ram_en,
    output logic                 o_ram_we,
    output logic [AW-1:0]        o_ram_addr,
    output logic [BPP*PPW-1:0]   o_ram_wdata,
    input  logic [BPP*PPW-1:0]   i_ram_rdata,
    input  logic                 i_cpu_req,
    input  logic                 i_cpu_we,
    input  logic [AW-1:0]        i_cpu_addr,
    input  logic [BPP*PPW-1:0]   i_cpu_wdata,
    output logic                 o_cpu_ack,
    output logic [BPP*PPW-1:0]   o_cpu_rdata,
    output logic                 o_pix_valid,
    output logic [BPP-1:0]       o_pix_rgb
);
    localparam int DW   = BPP * PPW;
    localparam int XLSB = (PPW > 1) ? $clog2(PPW) : 1;

    typedef enum logic [1:0] {S_IDLE, S_PEND, S_RESP} cpu_state_t;

    cpu_state_t      r_state;
    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [DW-1:0]   r_rdata;
    logic            r_ack;

    logic [AW-1:0]   r_faddr;
    logic            r_tick_d;
    logic            r_fetch_d;
    logic            r_von_d;
    logic [DW-1:0]   r_shift;
    logic [BPP-1:0]  r_pix_rgb;
    logic            r_pix_valid;

    logic            w_word_start;
    logic            w_dfetch;
    logic            w_frame0;
    logic [AW-1:0]   w_daddr;
    logic            w_cpu_go;

    assign w_word_start = (PPW == 1) ? 1'b1 : (i_x[XLSB-1:0] == '0);
    assign w_dfetch     = i_pix_tick & i_video_on & w_word_start & ~i_reset;
    assign w_frame0     = (i_x == '0) && (i_y == '0);
    // Scan address is a running counter re-synced at the top-left pixel.
    assign w_daddr      = w_frame0 ? '0 : r_faddr;
    assign w_cpu_go     = (r_state == S_PEND) & ~w_dfetch & ~i_reset;

    assign o_ram_en     = w_dfetch | w_cpu_go;
    assign o_ram_we     = w_cpu_go & r_we;
    assign o_ram_addr   = w_dfetch ? w_daddr : (w_cpu_go ? r_addr : '0);
    assign o_ram_wdata  = w_cpu_go ? r_wdata : '0;

    // Read data arrives in the ack cycle itself; afterwards the held copy is shown.
    assign o_cpu_ack    = r_ack;
    assign o_cpu_rdata  = (r_ack & ~r_we) ? i_ram_rdata : r_rdata;
    assign o_pix_valid  = r_pix_valid;
    assign o_pix_rgb    = r_pix_rgb;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_ack       <= 1'b0;
            r_faddr     <= '0;
            r_tick_d    <= 1'b0;
            r_fetch_d   <= 1'b0;
            r_von_d     <= 1'b0;
            r_shift     <= '0;
            r_pix_rgb   <= '0;
            r_pix_valid <= 1'b0;
        end else begin
            r_tick_d  <= i_pix_tick;
            r_fetch_d <= w_dfetch;
            r_von_d   <= i_video_on;
            if (w_dfetch)
                r_faddr <= w_daddr + AW'(1);

            // One cycle after each tick: new word unpacks LSB pixel first.
            if (r_tick_d) begin
                r_pix_valid <= r_von_d;
                if (!r_von_d) begin
                    r_pix_rgb <= '0;
                end else if (r_fetch_d) begin
                    r_pix_rgb <= i_ram_rdata[BPP-1:0];
                    r_shift   <= i_ram_rdata >> BPP;
                end else begin
                    r_pix_rgb <= r_shift[BPP-1:0];
                    r_shift   <= r_shift >> BPP;
                end
            end

            r_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_cpu_req) begin
                        r_we    <= i_cpu_we;
                        r_addr  <= i_cpu_addr;
                        r_wdata <= i_cpu_wdata;
                        r_state <= S_PEND;
                    end
                end
                S_PEND: begin
                    if (!w_dfetch) begin
                        r_ack   <= 1'b1;
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (!r_we)
                        r_rdata <= i_ram_rdata;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
